// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared LSU definitions: FSM states, access sizes and RISC-V load/store funct3 codes.
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic lsu_size_e decode_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input lsu_size_e sz);
    case (sz)
      SZ_BYTE: return 4'h1;
      SZ_HALF: return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input lsu_size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: enables and write shift for both words of an access, read extract and extend.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        zero_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word_lo,
  input  logic [31:0] word_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt;
  logic [7:0]  be64;
  logic [63:0] w64;
  logic [31:0] raw;

  always_comb begin
    shamt    = {offset, 3'b000};
    be64     = {4'b0000, size_mask(size)} << offset;
    w64      = {32'h0, wdata} << shamt;
    raw      = 32'({word_hi, word_lo} >> shamt);
    be_lo    = be64[3:0];
    be_hi    = be64[7:4];
    wdata_lo = w64[31:0];
    wdata_hi = w64[63:32];
    case (size)
      SZ_BYTE: rdata_ext = {{24{~zero_ext & raw[7]}}, raw[7:0]};
      SZ_HALF: rdata_ext = {{16{~zero_ext & raw[15]}}, raw[15:0]};
      default: rdata_ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one or two word accesses per request, then a done pulse.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        ls_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        ls_we_q, ls_we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word1_q, word1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;

  lsu_size_e   size;
  logic [2:0]  span;
  logic        split;
  logic [31:0] word_lo;
  logic [3:0]  be_lo, be_hi;
  logic [31:0] wdata_lo, wdata_hi, rdata_ext;

  assign size    = decode_size(funct3_q);
  assign span    = {1'b0, addr_q[1:0]} + size_bytes(size);
  assign split   = (span > 3'd4);
  // Single-word loads see their only word on mem_rdata during RESP.
  assign word_lo = split ? word1_q : mem_rdata;

  lsu_align u_align (
    .size      (size),
    .zero_ext  (funct3_q[2]),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .word_lo   (word_lo),
    .word_hi   (mem_rdata),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ls_we_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word1_q  <= 32'h0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ls_we_q  <= ls_we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word1_q  <= word1_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_ACC1;
      ST_ACC1: state_d = split ? ST_ACC2 : ST_RESP;
      ST_ACC2: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ls_we_d  = ls_we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word1_d  = word1_q;
    rdata_d  = rdata_q;
    done_d   = (state_q == ST_RESP);
    if (state_q == ST_IDLE && req) begin
      ls_we_d  = ls_we;
      funct3_d = funct3;
      addr_d   = addr;
      wdata_d  = wdata;
    end
    if (state_q == ST_ACC2) word1_d = mem_rdata;
    if (state_q == ST_RESP && !ls_we_q) rdata_d = rdata_ext;
  end

  always_comb begin
    ready     = (state_q == ST_IDLE);
    done      = done_q;
    rdata     = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 30'h0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      ST_ACC1: begin
        mem_en    = 1'b1;
        mem_we    = ls_we_q;
        mem_addr  = addr_q[31:2];
        mem_be    = be_lo;
        mem_wdata = wdata_lo;
      end
      ST_ACC2: begin
        mem_en    = 1'b1;
        mem_we    = ls_we_q;
        mem_addr  = addr_q[31:2] + 30'd1;
        mem_be    = be_hi;
        mem_wdata = wdata_hi;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-level reference model, per-cycle comparison, directed and random accesses.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ls_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ls_we(ls_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        dn;
    logic [31:0] rd;
    logic        en;
    logic        we;
    logic [29:0] ad;
    logic [3:0]  be;
    logic [31:0] wd;
  } cyc_t;

  int          n_checks = 0;
  int          n_err = 0;
  cyc_t        exp_q[$];
  logic [31:0] model_rdata = 32'h0;
  bit          chk_en = 1'b0;
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [3:0]  last_be1, last_be2;
  logic [29:0] last_w1;
  logic [31:0] last_wd1, last_wd2;
  bit          last_split;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic rdy, input logic dn, input logic [31:0] rd,
                              input logic en, input logic we, input logic [29:0] ad,
                              input logic [3:0] be, input logic [31:0] wd);
    cyc_t c;
    c.rdy = rdy; c.dn = dn; c.rd = rd; c.en = en; c.we = we; c.ad = ad; c.be = be; c.wd = wd;
    return c;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Reference model: walks the accessed bytes one address at a time.
  task automatic push_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    int          nb;
    logic [31:0] ba, tmp, v, wd1, wd2;
    logic [29:0] first;
    logic [3:0]  be1, be2;
    bit          sp;
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    first = a[31:2];
    be1 = 4'h0; be2 = 4'h0; wd1 = 32'h0; wd2 = 32'h0; v = 32'h0; sp = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ba = a + 32'(i);
      if (ba[31:2] == first) be1[ba[1:0]] = 1'b1;
      else begin be2[ba[1:0]] = 1'b1; sp = 1'b1; end
      tmp = rd_ref(ba[31:2]);
      if (we) begin
        tmp[8*ba[1:0] +: 8] = wd[8*i +: 8];
        ref_mem[ba[31:2]] = tmp;
      end else begin
        v[8*i +: 8] = tmp[8*ba[1:0] +: 8];
      end
    end
    for (int i = 0; i < 4; i++) begin
      int lane;
      lane = int'(a[1:0]) + i;
      if (lane < 4) wd1[8*lane +: 8] = wd[8*i +: 8];
      else          wd2[8*(lane-4) +: 8] = wd[8*i +: 8];
    end
    if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
    last_be1 = be1; last_be2 = be2; last_w1 = first;
    last_wd1 = wd1; last_wd2 = wd2; last_split = sp;
    exp_q.push_back(mk(1'b1, 1'b0, model_rdata, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0));
    exp_q.push_back(mk(1'b0, 1'b0, model_rdata, 1'b1, we, first, be1, wd1));
    if (sp) exp_q.push_back(mk(1'b0, 1'b0, model_rdata, 1'b1, we, first + 30'd1, be2, wd2));
    exp_q.push_back(mk(1'b0, 1'b0, model_rdata, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, we ? model_rdata : v, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold, output int lat);
    drain();
    ls_we = we; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
    push_txn(we, f3, a, wd);
    @(posedge clk); #1;
    if (hold) begin addr = a ^ 32'h10; ls_we = ~we; end
    else req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (done) lat = k;
    end
    $display("txn we=%0d f3=%0d addr=%h wdata=%h rdata=%h lat=%0d", we, f3, a, wd, rdata, lat);
  endtask

  // Memory responder: read data appears the cycle after mem_en.
  initial begin : mem_resp
    logic [31:0] w;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = w;
        end else begin
          mem_rdata <= w;
        end
      end
    end
  end

  initial begin : compare
    cyc_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(1'b1, 1'b0, model_rdata, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        if (e.dn) model_rdata = e.rd;
        chk("ready", 32'(ready), 32'(e.rdy));
        chk("done", 32'(done), 32'(e.dn));
        chk("rdata", rdata, e.rd);
        chk("mem_en", 32'(mem_en), 32'(e.en));
        chk("mem_be", 32'(mem_be), 32'(e.be));
        if (e.en) begin
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.ad));
          chk("mem_wdata", mem_wdata, e.wd);
        end else begin
          chk("mem_we_idle", 32'(mem_we), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          lat;
    logic [31:0] v;
    for (int i = 0; i < 9; i++) begin
      v = $urandom;
      mem[30'h40 + 30'(i)] = v;
      ref_mem[30'h40 + 30'(i)] = v;
    end
    mem[30'h40] = 32'h8899AABB;      ref_mem[30'h40] = 32'h8899AABB;
    mem[30'h41] = 32'h11223344;      ref_mem[30'h41] = 32'h11223344;
    mem[30'h3FFFFFFF] = 32'hCAFEF00D; ref_mem[30'h3FFFFFFF] = 32'hCAFEF00D;
    mem[30'h0] = 32'h01234567;       ref_mem[30'h0] = 32'h01234567;

    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    issue(1'b0, F3_LB, 32'h103, 32'h0, 1'b0, lat);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_rdata", rdata, 32'hFFFFFF88);
    chk("lb_be", 32'(last_be1), 32'h8);
    chk("lb_word", 32'(last_w1), 32'h40);

    issue(1'b0, F3_LHU, 32'h102, 32'h0, 1'b0, lat);
    chk("lhu_lat", 32'(lat), 32'd2);
    chk("lhu_rdata", rdata, 32'h00008899);
    chk("lhu_be", 32'(last_be1), 32'hC);

    issue(1'b0, F3_LW, 32'h102, 32'h0, 1'b0, lat);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rdata, 32'h33448899);
    chk("lw_be", 32'({last_be1, last_be2}), 32'hC3);

    issue(1'b1, F3_SH, 32'h103, 32'h0000BEEF, 1'b0, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_rdata_held", rdata, 32'h33448899);
    chk("sh_be", 32'({last_be1, last_be2}), 32'h81);
    chk("sh_wd1", last_wd1, 32'hEF000000);
    chk("sh_wd2", last_wd2, 32'h000000BE);

    issue(1'b0, F3_LW, 32'hFFFFFFFE, 32'h0, 1'b1, lat);
    chk("wrap_lat", 32'(lat), 32'd3);
    chk("wrap_rdata", rdata, 32'h4567CAFE);
    chk("wrap_word", 32'(last_w1), 32'h3FFFFFFF);

    // Reset in the middle of the second access of a split load.
    drain();
    chk_en = 1'b0;
    ls_we = 1'b0; funct3 = F3_LW; addr = 32'h106; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("abort_acc1_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    chk("abort_acc2_en", 32'(mem_en), 32'd1);
    chk("abort_acc2_addr", 32'(mem_addr), 32'h42);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_be", 32'(mem_be), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_en", 32'(mem_en), 32'd0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    model_rdata = 32'h0;
    chk_en = 1'b1;
    $display("txn reset abort of split load at 00000106");

    issue(1'b0, F3_LW, 32'h100, 32'h0, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_rdata", rdata, 32'hEF99AABB);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic        we;
      we = 1'($urandom_range(1, 0));
      f3 = 3'($urandom_range(7, 0));
      if ($urandom_range(7, 0) == 0) a = {30'h3FFFFFFF, 2'($urandom_range(3, 0))};
      else a = {30'h40 + 30'($urandom_range(7, 0)), 2'($urandom_range(3, 0))};
      issue(we, f3, a, $urandom, 1'($urandom_range(1, 0)), lat);
      chk("rand_lat", 32'(lat), last_split ? 32'd3 : 32'd2);
    end

    drain();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
